// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding,
// default register-index width and the hard-wired zero register index.
package hazard_ctrl_pkg;

  localparam int REG_W_DEF = 4;
  localparam int ZERO_REG_IDX = 0;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN      = 2'd0;
  localparam state_t ST_LD_STALL = 2'd1;
  localparam state_t ST_MC_BUSY  = 2'd2;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of
// wrapping so long stalls never alias to small counts.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Count register: clear wins over increment, increment stops at all-ones.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= {W{1'b0}};
    end else if (clear) begin
      count_r <= {W{1'b0}};
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/hazard_ctrl.sv
// Central pipeline control: combinational hold/flush strobes for IF/ID, ID/EX,
// EX/MEM and the PC, sequenced by a small FSM for load-use and multi-cycle ops.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W  = REG_W_DEF,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic             ex_branch_taken,
  input  logic             ex_mc_start,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_hold,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  // mc_cnt holds the MC_BUSY cycles still to go, including the current one.
  localparam logic [CW-1:0] MC_LOAD = CW'(MC_LAT - 2);
  localparam logic [REG_W-1:0] ZERO_R = REG_W'(ZERO_REG_IDX);

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] mc_cnt_r, mc_cnt_nxt_s;
  logic          load_use_s;
  logic          pc_hold_s, ifid_hold_s, ifid_flush_s;
  logic          idex_hold_s, idex_flush_s, exmem_flush_s;

  assign load_use_s = ex_mem_read && ex_reg_write && (ex_rd != ZERO_R) &&
                      ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

  // Next-state, latency counter and raw strobe decode.
  always_comb begin
    state_nxt_s   = state_r;
    mc_cnt_nxt_s  = mc_cnt_r;
    pc_hold_s     = 1'b0;
    ifid_hold_s   = 1'b0;
    ifid_flush_s  = 1'b0;
    idex_hold_s   = 1'b0;
    idex_flush_s  = 1'b0;
    exmem_flush_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (ex_branch_taken) begin
          ifid_flush_s = 1'b1;
          idex_flush_s = 1'b1;
        end else if (ex_mc_start) begin
          pc_hold_s     = 1'b1;
          ifid_hold_s   = 1'b1;
          idex_hold_s   = 1'b1;
          exmem_flush_s = 1'b1;
          mc_cnt_nxt_s  = MC_LOAD;
          if (MC_LAT > 2) begin
            state_nxt_s = ST_MC_BUSY;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else if (load_use_s) begin
          pc_hold_s    = 1'b1;
          ifid_hold_s  = 1'b1;
          idex_flush_s = 1'b1;
          state_nxt_s  = ST_LD_STALL;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_LD_STALL: begin
        if (ex_branch_taken) begin
          ifid_flush_s = 1'b1;
          idex_flush_s = 1'b1;
        end else begin
          ifid_flush_s = 1'b0;
        end
        state_nxt_s = ST_RUN;
      end
      ST_MC_BUSY: begin
        pc_hold_s     = 1'b1;
        ifid_hold_s   = 1'b1;
        idex_hold_s   = 1'b1;
        exmem_flush_s = 1'b1;
        if (mc_cnt_r <= CW'(1)) begin
          mc_cnt_nxt_s = {CW{1'b0}};
          state_nxt_s  = ST_RUN;
        end else begin
          mc_cnt_nxt_s = mc_cnt_r - CW'(1);
        end
      end
      default: begin
        mc_cnt_nxt_s = {CW{1'b0}};
        state_nxt_s  = ST_RUN;
      end
    endcase
  end

  // FSM state and multi-cycle latency counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_RUN;
      mc_cnt_r <= {CW{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      mc_cnt_r <= mc_cnt_nxt_s;
    end
  end

  // Output gating: every strobe reads 0 while reset is held low.
  always_comb begin
    if (!reset) begin
      pc_hold     = 1'b0;
      ifid_hold   = 1'b0;
      ifid_flush  = 1'b0;
      idex_hold   = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      busy        = 1'b0;
    end else begin
      pc_hold     = pc_hold_s;
      ifid_hold   = ifid_hold_s;
      ifid_flush  = ifid_flush_s;
      idex_hold   = idex_hold_s;
      idex_flush  = idex_flush_s;
      exmem_flush = exmem_flush_s;
      busy        = (state_r != ST_RUN);
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .clear (1'b0),
    .inc   (pc_hold),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic compared cycle by cycle against a stall-budget reference model.
module tb_hazard_ctrl;

  localparam int REG_W  = 4;
  localparam int MC_LAT = 4;
  localparam int CNT_W  = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [REG_W-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic             id_uses_rs2 = 1'b0, ex_mem_read = 1'b0, ex_reg_write = 1'b0;
  logic             ex_branch_taken = 1'b0, ex_mc_start = 1'b0;
  logic             pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush;
  logic             exmem_flush, busy;
  logic [CNT_W-1:0] stall_cycles;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: remaining multi-cycle stall cycles, load-use cooldown, count.
  int m_mc_left = 0;
  bit m_ld      = 1'b0;
  int m_cnt     = 0;

  hazard_ctrl #(.REG_W(REG_W), .MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .ex_branch_taken(ex_branch_taken),
    .ex_mc_start(ex_mc_start), .pc_hold(pc_hold), .ifid_hold(ifid_hold),
    .ifid_flush(ifid_flush), .idex_hold(idex_hold), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .busy(busy), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic [6:0] outs();
    return {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_flush, busy};
  endfunction

  // Drive one cycle of inputs (called just after a rising edge), compare at the
  // falling edge against the model, advance the model, return after next edge.
  task automatic step(input logic br, input logic mcs, input logic mr, input logic rw,
                      input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs1,
                      input logic [REG_W-1:0] rs2, input logic u2);
    logic ph, ih, ifl, dh, dfl, ef, bz, hit;
    ex_branch_taken = br; ex_mc_start = mcs; ex_mem_read = mr; ex_reg_write = rw;
    ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2;
    {ph, ih, ifl, dh, dfl, ef, bz} = 7'b0;
    hit = mr && rw && (rd != 0) && ((rd == rs1) || (u2 && (rd == rs2)));
    if (m_mc_left > 0) begin
      {ph, ih, dh, ef, bz} = 5'b11111;
      m_mc_left--;
    end else if (m_ld) begin
      bz = 1'b1;
      if (br) {ifl, dfl} = 2'b11;
      m_ld = 1'b0;
    end else if (br) begin
      {ifl, dfl} = 2'b11;
    end else if (mcs) begin
      {ph, ih, dh, ef} = 4'b1111;
      m_mc_left = MC_LAT - 2;
    end else if (hit) begin
      {ph, ih, dfl} = 3'b111;
      m_ld = 1'b1;
    end
    @(negedge clock);
    check("strobes", {25'd0, outs()}, {25'd0, ph, ih, ifl, dh, dfl, ef, bz});
    check("stall_cycles", {28'd0, stall_cycles}, m_cnt);
    check("ifid_excl", {31'd0, ifid_hold & ifid_flush}, 32'd0);
    check("idex_excl", {31'd0, idex_hold & idex_flush}, 32'd0);
    if (ph && m_cnt < (2 ** CNT_W) - 1) m_cnt++;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
  endtask

  // Assert reset between edges: outputs must drop at once, model restarts.
  task automatic reset_pulse();
    #2 reset = 1'b0;
    #1;
    check("reset_outs", {25'd0, outs()}, 32'd0);
    check("reset_cnt", {28'd0, stall_cycles}, 32'd0);
    m_mc_left = 0; m_ld = 1'b0; m_cnt = 0;
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin
    @(posedge clock);
    #1;
    ex_branch_taken = 1'b1; ex_mc_start = 1'b1;
    #1;
    check("in_reset_outs", {25'd0, outs()}, 32'd0);
    check("in_reset_cnt", {28'd0, stall_cycles}, 32'd0);
    ex_branch_taken = 1'b0; ex_mc_start = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Load-use on rs1: one stall, one busy cycle, then quiet.
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 4'd3, 4'd0, 1'b0);
    idle(); idle();
    check("lu_count", {28'd0, stall_cycles}, 32'd1);

    // Zero register never stalls; rs2 only matters when used.
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 4'd1, 4'd5, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 4'd1, 4'd5, 1'b1);
    idle();
    check("rs2_count", {28'd0, stall_cycles}, 32'd2);

    // Branch overrides coincident load-use and stays in RUN.
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 4'd7, 4'd0, 1'b0);
    idle();

    // Multi-cycle op with a branch injected mid-stall.
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    idle(); idle();
    check("mc_count", {28'd0, stall_cycles}, 32'd5);

    // Saturation: 21 back-to-back stall cycles.
    reset_pulse();
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
      idle(); idle();
    end
    idle();
    check("sat_count", {28'd0, stall_cycles}, 32'hF);

    // Reset in the middle of a multi-cycle stall.
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    reset_pulse();
    idle();
    check("post_reset_busy", {31'd0, busy}, 32'd0);

    // Randomized traffic with small register indices to provoke hits.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) reset_pulse();
      step($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
           1'($urandom), 1'($urandom),
           4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           4'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
